bitrev_sched: RTL



---
 rtl/bitrev_sched_if.sv | 49 ++++
 rtl/bitrev_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bitrev_sched_if.sv
// ============================================================================
// Module      : bitrev_sched_if
// Description : Request/response bundle for the bit-reverse/permute
//               sequencer: two valid/ready requesters, one response port
//               and a busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bitrev_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [1:0]       req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [1:0]       req1_mode;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    logic             busy;

    // Requesters and response consumer side
    modport master (
        output req0_valid, req0_data, req0_mode,
        output req1_valid, req1_data, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

    // Sequencer side
    modport slave (
        input  req0_valid, req0_data, req0_mode,
        input  req1_valid, req1_data, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/bitrev_sched.sv
// ============================================================================
// Module      : bitrev_sched
// Description : Two-port arbiter and sequencer for the shared bit-reverse /
//               permute unit. Grants one request at a time, spends
//               EXEC_CYCLES in EXEC, then holds the tagged result until the
//               consumer takes it.
//               Optional macro BITREV_SCHED_RR_EN: round-robin arbitration
//               (undefined: fixed priority, requester 0 wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitrev_sched #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bitrev_sched_if.slave      bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EXEC     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam int         c_BYTES    = WIDTH / 8;
    localparam logic [3:0] c_CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_ptr;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_op_data;
    logic [1:0]       r_op_mode;
    logic             r_id;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_data;
    logic [1:0]       w_op_mode;
    logic [WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] f_permute(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            2'b00: begin
                for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
            end
            2'b01: begin
                for (int b = 0; b < c_BYTES; b++)
                    for (int i = 0; i < 8; i++) r[8*b+i] = d[8*b+7-i];
            end
            2'b10: begin
                for (int b = 0; b < c_BYTES; b++)
                    r[8*b +: 8] = d[8*(c_BYTES-1-b) +: 8];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Arbitration: a lone valid wins; on a tie the pointer decides
    always_comb begin
        w_grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) w_grant_id = r_ptr;
        else if (bus.req1_valid)              w_grant_id = 1'b1;
        w_op_data = w_grant_id ? bus.req1_data : bus.req0_data;
        w_op_mode = w_grant_id ? bus.req1_mode : bus.req0_mode;
        w_result  = f_permute(r_op_data, r_op_mode);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)        w_next_state = c_EXEC;
            c_EXEC:  if (r_cnt == 4'd0)   w_next_state = c_RESP;
            c_RESP:  if (bus.rsp_ready)   w_next_state = c_IDLE;
            default:                      w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the grant
    always_comb begin
        bus.req0_ready = (r_state == c_IDLE) && bus.req0_valid && !w_grant_id;
        bus.req1_ready = (r_state == c_IDLE) && bus.req1_valid &&  w_grant_id;
        w_accept       = bus.req0_ready || bus.req1_ready;
        bus.rsp_valid  = (r_state == c_RESP);
        bus.busy       = (r_state != c_IDLE);
        bus.rsp_data   = r_rsp_data;
        bus.rsp_id     = r_id;
    end

    // Operand capture, exec countdown, result capture and priority pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 1'b0;
            r_cnt      <= 4'd0;
            r_op_data  <= '0;
            r_op_mode  <= 2'b00;
            r_id       <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op_data <= w_op_data;
                r_op_mode <= w_op_mode;
                r_id      <= w_grant_id;
                r_cnt     <= c_CNT_INIT;
`ifdef BITREV_SCHED_RR_EN
                r_ptr     <= ~w_grant_id;
`else
                r_ptr     <= 1'b0;
`endif
            end
            if (r_state == c_EXEC) begin
                if (r_cnt == 4'd0) r_rsp_data <= w_result;
                else               r_cnt      <= r_cnt - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire
